// File: rtl/mmio_output_fifo.sv
// Memory-mapped output FIFO: CPU pushes bytes by writing the data-port address,
// a downstream consumer drains them with a valid/ready handshake, and a status
// register reports empty/full/overflow. The overflow flag is cleared by writing
// the status address.
module mmio_output_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR = '1,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(OUT_ADDR - 1'b1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        memAddress,
  input  logic [DATA_WIDTH-1:0]        memIn,
  input  logic                         memWrEnable,
  output logic [DATA_WIDTH-1:0]        statusOut,
  output logic [DATA_WIDTH-1:0]        outData,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  clearOvf;
  logic                  isFull;
  logic                  isEmpty;

  // Decode CPU writes and the consumer handshake; a push into a full FIFO is
  // only accepted when a pop frees a slot on the same edge.
  always_comb begin
    isEmpty  = (count == '0);
    isFull   = (count == CNT_W'(DEPTH));
    push     = memWrEnable && (memAddress == OUT_ADDR);
    clearOvf = memWrEnable && (memAddress == STATUS_ADDR);
    pop      = outValid && outReady;
    accept   = push && (!isFull || pop);
  end

  // Head of FIFO is presented straight from storage at the read pointer.
  assign outValid = !isEmpty;
  assign outData  = mem[rdPtr];

  // Entry storage; contents need no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wrPtr] <= memIn;
    end
  end

  // Pointers, occupancy and the sticky overflow flag; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (accept && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !accept) begin
        count <= count - CNT_W'(1);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end else if (clearOvf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Status register read path, combinational on the address bus.
  always_comb begin
    statusOut = '0;
    if (memAddress == STATUS_ADDR) begin
      statusOut[0] = isEmpty;
      statusOut[1] = isFull;
      statusOut[2] = overflow;
    end
  end

endmodule

// File: tb/tb_mmio_output_fifo.sv
// Bench for mmio_output_fifo: a queue-based reference model checked on every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_mmio_output_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] memAddress;
  logic [7:0] memIn;
  logic       memWrEnable;
  logic [7:0] statusOut;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [2:0] count;
  logic       overflow;

  int total = 0;
  int bad = 0;

  mmio_output_fifo dut (
    .clk(clk),
    .rst(rst),
    .memAddress(memAddress),
    .memIn(memIn),
    .memWrEnable(memWrEnable),
    .statusOut(statusOut),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] dutSeen[$];
  bit         ovfM = 1'b0;
  bit         armed = 1'b0;
  bit         mPop, mPush, mFull;
  logic [7:0] expStat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on the active edge from the specification's rules
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ovfM  = 1'b0;
      armed = 1'b1;
    end else begin
      mFull = (q.size() == 4);
      mPop  = (q.size() != 0) && (outReady === 1'b1);
      mPush = (memWrEnable === 1'b1) && (memAddress == 8'hFF);
      if (mPop) void'(q.pop_front());
      if (mPush) begin
        if (!mFull || mPop) q.push_back(memIn);
        else ovfM = 1'b1;
      end
      if ((memWrEnable === 1'b1) && (memAddress == 8'hFE)) ovfM = 1'b0;
    end
  end

  // Compare DUT against model away from the active edge; log consumed data
  always @(negedge clk) begin
    if (armed) begin
      expStat = 8'h00;
      if (memAddress == 8'hFE) expStat = {5'b0, ovfM, q.size() == 4, q.size() == 0};
      chk("count", 32'(count), 32'(q.size()));
      chk("outValid", 32'(outValid), 32'(q.size() != 0));
      chk("overflow", 32'(overflow), 32'(ovfM));
      if (q.size() != 0) chk("outData", 32'(outData), 32'(q[0]));
      chk("statusOut", 32'(statusOut), 32'(expStat));
      if (outValid === 1'b1 && outReady === 1'b1) dutSeen.push_back(outData);
    end
  end

  // Apply inputs, let one rising edge sample them, return just after it
  task automatic drive(input logic r, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic rdy);
    rst = r; memWrEnable = we; memAddress = a; memIn = d; outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  // Non-writing look at an address so statusOut can be checked
  task automatic peek(input logic [7:0] a);
    memWrEnable = 1'b0; memAddress = a;
    #1;
  endtask

  task automatic chkSeen(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, 32'(dutSeen.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dutSeen.size(); i++)
      chk(nm, 32'(dutSeen[i]), 32'(exp[i]));
    dutSeen.delete();
  endtask

  initial begin
    logic [7:0] e[$];
    rst = 1'b1; memWrEnable = 1'b0; memAddress = 8'h00; memIn = 8'h00; outReady = 1'b0;
    drive(1, 0, 8'h00, 8'h00, 0);
    drive(1, 0, 8'h00, 8'h00, 0);
    drive(0, 0, 8'h00, 8'h00, 0);

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    peek(8'hFE);
    chk("rst_status", 32'(statusOut), 32'h01);

    // Fill to full with consumer stalled
    for (int i = 1; i <= 4; i++) drive(0, 1, 8'hFF, 8'(i), 0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_valid", 32'(outValid), 32'd1);
    chk("fill_data", 32'(outData), 32'h01);
    chk("fill_ovf", 32'(overflow), 32'd0);
    peek(8'hFE);
    chk("fill_status", 32'(statusOut), 32'h02);

    // Push into full FIFO is dropped and flags overflow; status write clears it
    drive(0, 1, 8'hFF, 8'h05, 0);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_data", 32'(outData), 32'h01);
    peek(8'hFE);
    chk("drop_status", 32'(statusOut), 32'h06);
    drive(0, 1, 8'hFE, 8'h5A, 0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    peek(8'hFE);
    chk("clr_status", 32'(statusOut), 32'h02);

    // Simultaneous push and pop at full, then drain
    drive(0, 1, 8'hFF, 8'h05, 1);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_data", 32'(outData), 32'h02);
    repeat (4) drive(0, 0, 8'h00, 8'h00, 1);
    chk("drain_valid", 32'(outValid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    peek(8'hFE);
    chk("drain_status", 32'(statusOut), 32'h01);
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chkSeen("drain_seq", e);

    // Push into empty FIFO with consumer ready: visible next cycle, then popped
    drive(0, 1, 8'hFF, 8'hAA, 1);
    chk("one_valid", 32'(outValid), 32'd1);
    chk("one_data", 32'(outData), 32'hAA);
    drive(0, 0, 8'h00, 8'h00, 1);
    chk("one_count", 32'(count), 32'd0);
    e = '{8'hAA};
    chkSeen("one_seq", e);

    // Ten entries with outReady toggling every cycle; pointers wrap
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) drive(0, 1, 8'hFF, 8'(c / 2), 1'b0);
      else drive(0, 0, 8'h00, 8'h00, 1'b1);
    end
    repeat (3) drive(0, 0, 8'h00, 8'h00, 1);
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_count", 32'(count), 32'd0);
    e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    chkSeen("wrap_seq", e);

    // Mid-stream reset with concurrent push discards everything
    for (int i = 1; i <= 5; i++) drive(0, 1, 8'hFF, 8'(8'h11 * i), 0);
    drive(0, 0, 8'h00, 8'h00, 1);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    dutSeen.delete();
    drive(1, 1, 8'hFF, 8'h66, 0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(outValid), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    drive(0, 1, 8'hFF, 8'h77, 0);
    chk("post_rst_data", 32'(outData), 32'h77);
    drive(0, 0, 8'h00, 8'h00, 1);
    drive(0, 0, 8'h00, 8'h00, 0);
    e = '{8'h77};
    chkSeen("post_rst_seq", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
